// File: rtl/axis_ads4246_frame_fifo.sv
// First-word-fall-through AXI-Stream buffer for ADS4246 sample words.
// Emits fixed-length frames with regenerated TLAST and checks the incoming TLAST.
module axis_ads4246_frame_fifo #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH_LOG2  = 4,
  parameter int C_FRAME_LEN        = 8
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic                              M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              ENABLE,
  input  logic                              CLR_ERR,
  output logic [C_FIFO_DEPTH_LOG2:0]        FIFO_COUNT,
  output logic [15:0]                       FRAME_CNT,
  output logic                              LEN_ERR
);

  localparam int DW    = C_AXIS_TDATA_WIDTH;
  localparam int SW    = C_AXIS_TDATA_WIDTH / 8;
  localparam int AW    = C_FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << C_FIFO_DEPTH_LOG2;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(C_FRAME_LEN - 1);

  logic [SW+DW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [15:0]      in_idx;
  logic [15:0]      out_idx;
  logic [15:0]      frame_cnt;
  logic             len_err;

  logic             push;
  logic             pop;
  logic             in_last_exp;
  logic             out_last;
  logic [SW+DW-1:0] head;

  always_comb begin
    S_AXIS_TREADY = S_AXIS_ARESETN && ENABLE && (count != FULL_CNT);
    M_AXIS_TVALID = (count != '0);
    push          = S_AXIS_TVALID && S_AXIS_TREADY;
    pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    in_last_exp   = (in_idx == LAST_IDX);
    out_last      = M_AXIS_TVALID && (out_idx == LAST_IDX);
    head          = mem[rd_ptr];
  end

  // Head word is forced to zero while empty so reset shows clean outputs
  // even though the storage array itself is never reset.
  assign M_AXIS_TDATA = M_AXIS_TVALID ? head[DW-1:0]       : '0;
  assign M_AXIS_TSTRB = M_AXIS_TVALID ? head[SW+DW-1:DW]   : '0;
  assign M_AXIS_TLAST = out_last;
  assign FIFO_COUNT   = count;
  assign FRAME_CNT    = frame_cnt;
  assign LEN_ERR      = len_err;

  // Storage: data path, written on push only, no reset
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) begin
      mem[wr_ptr] <= {S_AXIS_TSTRB, S_AXIS_TDATA};
    end
  end

  // Occupancy and pointers
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Input framing check; in_idx free-runs and is never realigned by TLAST
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      in_idx  <= '0;
      len_err <= 1'b0;
    end else begin
      if (push) begin
        in_idx <= in_last_exp ? '0 : in_idx + 1'b1;
      end
      if (push && (S_AXIS_TLAST != in_last_exp)) begin
        len_err <= 1'b1;
      end else if (CLR_ERR) begin
        len_err <= 1'b0;
      end
    end
  end

  // Output framing
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      out_idx   <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      if (out_last) begin
        out_idx   <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        out_idx   <= out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_ads4246_frame_fifo.sv
// Bench for axis_ads4246_frame_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_axis_ads4246_frame_fifo;

  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        enable = 1'b1;
  logic        clr_err = 1'b0;
  logic [4:0]  fifo_count;
  logic [15:0] frame_cnt;
  logic        len_err;

  int nvec = 0;
  int nerr = 0;

  axis_ads4246_frame_fifo #(
    .C_AXIS_TDATA_WIDTH(32),
    .C_FIFO_DEPTH_LOG2(4),
    .C_FRAME_LEN(L)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TSTRB(s_tstrb),
    .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TSTRB(m_tstrb),
    .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready),
    .ENABLE(enable),
    .CLR_ERR(clr_err),
    .FIFO_COUNT(fifo_count),
    .FRAME_CNT(frame_cnt),
    .LEN_ERR(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, framing from total push/pop counts
  logic [35:0] mq[$];
  int          m_pushes = 0;
  int          m_pops = 0;
  logic        m_err = 1'b0;

  // Handshake log, as seen by an external observer
  logic [32:0] olog[$];
  int          acc = 0;

  always @(negedge clk) begin
    logic exp_rdy, exp_vld, exp_last, do_push, do_pop;
    if (!rst_n) begin
      mq.delete();
      m_pushes = 0;
      m_pops = 0;
      m_err = 1'b0;
      olog.delete();
      acc = 0;
    end
    exp_rdy  = rst_n && enable && (mq.size() != 16);
    exp_vld  = (mq.size() != 0);
    exp_last = exp_vld && ((m_pops % L) == L - 1);
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_vld));
    chk("m_tlast", 64'(m_tlast), 64'(exp_last));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("frame_cnt", 64'(frame_cnt), 64'((m_pops / L) % 65536));
    chk("len_err", 64'(len_err), 64'(m_err));
    if (exp_vld) begin
      chk("m_tdata", 64'(m_tdata), 64'(mq[0][31:0]));
      chk("m_tstrb", 64'(m_tstrb), 64'(mq[0][35:32]));
    end else if (!rst_n) begin
      chk("m_tdata_rst", 64'(m_tdata), 64'd0);
      chk("m_tstrb_rst", 64'(m_tstrb), 64'd0);
    end
    if (rst_n) begin
      do_push = s_tvalid && exp_rdy;
      do_pop  = exp_vld && m_tready;
      if (do_push && (s_tlast != ((m_pushes % L) == L - 1))) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      if (do_pop) begin
        void'(mq.pop_front());
        m_pops++;
      end
      if (do_push) begin
        mq.push_back({s_tstrb, s_tdata});
        m_pushes++;
      end
      if (s_tvalid && s_tready) acc++;
      if (m_tvalid && m_tready) olog.push_back({m_tlast, m_tdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    enable = 1'b1;
    clr_err = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tstrb = d[3:0] ^ 4'hA;
    s_tlast = last;
    step();
  endtask

  initial begin
    // Reset hold with upstream valid asserted
    s_tvalid = 1'b1;
    s_tdata = 32'hAAAABBBB;
    s_tstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
    end
    rst_n = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("first_count", 64'(fifo_count), 64'd1);
    chk("first_data", 64'(m_tdata), 64'hAAAABBBB);
    step();

    // 16-word stream, two frames
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'(i), (i % 8) == 7);
    s_tvalid = 1'b0;
    steps(2);
    chk("stream_len", 64'(olog.size()), 64'd16);
    for (int i = 0; i < 16 && i < olog.size(); i++) begin
      chk("stream_data", 64'(olog[i][31:0]), 64'(i));
      chk("stream_last", 64'(olog[i][32]), 64'((i == 7) || (i == 15)));
    end
    chk("stream_frames", 64'(frame_cnt), 64'd2);
    chk("stream_err", 64'(len_err), 64'd0);

    // Backpressure: fill to 16, refuse push coincident with first pop
    do_reset();
    for (int i = 0; i < 20; i++) send(32'(i), (i % 8) == 7);
    chk("full_acc", 64'(acc), 64'd16);
    chk("full_count", 64'(fifo_count), 64'd16);
    chk("full_tready", 64'(s_tready), 64'd0);
    s_tdata = 32'h99;
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("full_refuse_acc", 64'(acc), 64'd16);
    chk("full_refuse_cnt", 64'(fifo_count), 64'd15);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    steps(17);
    chk("drain_len", 64'(olog.size()), 64'd16);
    for (int i = 0; i < 16 && i < olog.size(); i++)
      chk("drain_data", 64'(olog[i][31:0]), 64'(i));
    chk("drain_count", 64'(fifo_count), 64'd0);

    // Input framing error on word 3
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'(i + 32'h100), (i == 3) || (i == 7));
      if (i == 3) chk("err_set", 64'(len_err), 64'd1);
    end
    s_tvalid = 1'b0;
    steps(2);
    chk("err_sticky", 64'(len_err), 64'd1);
    if (olog.size() == 8) begin
      chk("err_last3", 64'(olog[3][32]), 64'd0);
      chk("err_last7", 64'(olog[7][32]), 64'd1);
    end else chk("err_len", 64'(olog.size()), 64'd8);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("err_clr", 64'(len_err), 64'd0);
    clr_err = 1'b1;
    send(32'h200, 1'b1);
    clr_err = 1'b0;
    s_tvalid = 1'b0;
    chk("err_set_wins", 64'(len_err), 64'd1);
    steps(2);

    // ENABLE low: input blocked, FIFO drains
    do_reset();
    for (int i = 0; i < 5; i++) send(32'(i + 32'h10), 1'b0);
    enable = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = 32'hCCCCDDDD;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    step();
    chk("en_tready", 64'(s_tready), 64'd0);
    steps(6);
    chk("en_count", 64'(fifo_count), 64'd0);
    chk("en_acc", 64'(acc), 64'd5);
    chk("en_drained", 64'(olog.size()), 64'd5);
    enable = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("en_acc2", 64'(acc), 64'd6);
    step();
    if (olog.size() == 6) chk("en_word", 64'(olog[5][31:0]), 64'hCCCCDDDD);
    else chk("en_len", 64'(olog.size()), 64'd6);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) send(32'(i + 32'h300), 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_count", 64'(fifo_count), 64'd0);
    chk("mid_tdata", 64'(m_tdata), 64'd0);
    chk("mid_tlast", 64'(m_tlast), 64'd0);
    chk("mid_tready", 64'(s_tready), 64'd0);
    step();
    rst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'(i + 32'h400), i == 7);
    s_tvalid = 1'b0;
    steps(2);
    if (olog.size() == 8) begin
      chk("mid_last6", 64'(olog[6][32]), 64'd0);
      chk("mid_last7", 64'(olog[7][32]), 64'd1);
    end else chk("mid_len", 64'(olog.size()), 64'd8);
    chk("mid_frames", 64'(frame_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
